mem_port_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the pipeline's instruction-fetch stage (IF) and memory-access stage (MEM). It holds the memory for a fixed `LATENCY`-cycle access and returns data with a one-cycle ready pulse. The requesting stage stalls on `~Ready`, so the hazard/stall logic can hold `PC_Write` and the inter-stage register enables. Arbitration is MEM-priority with alternation, so neither requester starves.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM requester handshakes and the single-port memory bus.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if;
   logic        IF_Req;
   logic [31:0] IF_Address;
   logic        IF_Ready;
   logic [31:0] IF_Data;

   logic        MEM_Req;
   logic        MEM_Write;
   logic [1:0]  MEM_Size;
   logic [31:0] MEM_Address;
   logic [31:0] MEM_WriteData;
   logic        MEM_Ready;
   logic [31:0] MEM_ReadData;

   logic        Mem_En;
   logic        Mem_WE;
   logic [1:0]  Mem_Size;
   logic [31:0] Mem_Address;
   logic [31:0] Mem_WriteData;
   logic [31:0] Mem_ReadData;

   modport master (
      output IF_Req, IF_Address,
      output MEM_Req, MEM_Write, MEM_Size, MEM_Address, MEM_WriteData,
      output Mem_ReadData,
      input  IF_Ready, IF_Data, MEM_Ready, MEM_ReadData,
      input  Mem_En, Mem_WE, Mem_Size, Mem_Address, Mem_WriteData
   );

   modport slave (
      input  IF_Req, IF_Address,
      input  MEM_Req, MEM_Write, MEM_Size, MEM_Address, MEM_WriteData,
      input  Mem_ReadData,
      output IF_Ready, IF_Data, MEM_Ready, MEM_ReadData,
      output Mem_En, Mem_WE, Mem_Size, Mem_Address, Mem_WriteData
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and data access.
// Fixed-latency accesses, MEM-priority arbitration that alternates under contention.
module mem_port_arbiter #(
   parameter int LATENCY = 2
) (
   input logic               Clk,
   input logic               Reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LAST_COUNT = (LATENCY < 1) ? 4'd1 : 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {GRANT_IF, GRANT_MEM} grant_t;

   state_t      state, next_state;
   logic [3:0]  count, next_count;
   grant_t      last_grant, next_last_grant;
   grant_t      owner, next_owner;
   logic        if_ready, next_if_ready;
   logic        mem_ready, next_mem_ready;
   logic [31:0] if_data, next_if_data;
   logic [31:0] read_data, next_read_data;
   logic        mem_en, next_mem_en;
   logic        mem_we, next_mem_we;
   logic [1:0]  mem_size, next_mem_size;
   logic [31:0] mem_address, next_mem_address;
   logic [31:0] write_data, next_write_data;
   logic        if_eligible, mem_eligible, pick_mem;

   assign bus.IF_Ready      = if_ready;
   assign bus.IF_Data       = if_data;
   assign bus.MEM_Ready     = mem_ready;
   assign bus.MEM_ReadData  = read_data;
   assign bus.Mem_En        = mem_en;
   assign bus.Mem_WE        = mem_we;
   assign bus.Mem_Size      = mem_size;
   assign bus.Mem_Address   = mem_address;
   assign bus.Mem_WriteData = write_data;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         count       <= 4'd0;
         last_grant  <= GRANT_IF;
         owner       <= GRANT_IF;
         if_ready    <= 1'b0;
         mem_ready   <= 1'b0;
         if_data     <= 32'd0;
         read_data   <= 32'd0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_size    <= 2'b00;
         mem_address <= 32'd0;
         write_data  <= 32'd0;
      end else begin
         state       <= next_state;
         count       <= next_count;
         last_grant  <= next_last_grant;
         owner       <= next_owner;
         if_ready    <= next_if_ready;
         mem_ready   <= next_mem_ready;
         if_data     <= next_if_data;
         read_data   <= next_read_data;
         mem_en      <= next_mem_en;
         mem_we      <= next_mem_we;
         mem_size    <= next_mem_size;
         mem_address <= next_mem_address;
         write_data  <= next_write_data;
      end
   end

   // In DONE the requester just served still shows its old Req, so it is not eligible again.
   always_comb begin
      next_state       = state;
      next_count       = count;
      next_last_grant  = last_grant;
      next_owner       = owner;
      next_if_ready    = 1'b0;
      next_mem_ready   = 1'b0;
      next_if_data     = if_data;
      next_read_data   = read_data;
      next_mem_en      = 1'b0;
      next_mem_we      = mem_we;
      next_mem_size    = mem_size;
      next_mem_address = mem_address;
      next_write_data  = write_data;

      if_eligible  = bus.IF_Req  && ((state == IDLE) || (state == DONE && owner != GRANT_IF));
      mem_eligible = bus.MEM_Req && ((state == IDLE) || (state == DONE && owner != GRANT_MEM));
      pick_mem     = mem_eligible && (!if_eligible || last_grant == GRANT_IF);

      case (state)
         IDLE, DONE: begin
            next_mem_we = 1'b0;
            if (if_eligible || mem_eligible) begin
               next_state      = ACCESS;
               next_count      = 4'd1;
               next_mem_en     = 1'b1;
               next_owner      = pick_mem ? GRANT_MEM : GRANT_IF;
               next_last_grant = pick_mem ? GRANT_MEM : GRANT_IF;
               if (pick_mem) begin
                  next_mem_we      = bus.MEM_Write;
                  next_mem_size    = bus.MEM_Size;
                  next_mem_address = bus.MEM_Address;
                  if (bus.MEM_Write) begin
                     next_write_data = bus.MEM_WriteData;
                  end
               end else begin
                  next_mem_size    = 2'b01;
                  next_mem_address = bus.IF_Address;
               end
            end else begin
               next_state = IDLE;
            end
         end
         ACCESS: begin
            if (count < LAST_COUNT) begin
               next_count  = count + 4'd1;
               next_mem_en = 1'b1;
            end else begin
               next_state  = DONE;
               next_mem_we = 1'b0;
               if (owner == GRANT_IF) begin
                  next_if_ready = 1'b1;
                  next_if_data  = bus.Mem_ReadData;
               end else begin
                  next_mem_ready = 1'b1;
                  if (!mem_we) begin
                     next_read_data = bus.Mem_ReadData;
                  end
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants and
// timing, and per-requester scoreboards check returned data on each Ready pulse.
module tb_mem_port_arbiter;
   localparam int LAT = 3;

   typedef struct {
      bit          isMem;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
   } access_t;

   typedef struct {
      bit          isStore;
      logic [31:0] addr;
   } memExp_t;

   logic clk;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.LATENCY(LAT)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   logic        ifReq, memReq, memWrite;
   logic [1:0]  memSize;
   logic [31:0] ifAddr, memAddr, memWdata, memRdata;

   assign bus.IF_Req        = ifReq;
   assign bus.IF_Address    = ifAddr;
   assign bus.MEM_Req       = memReq;
   assign bus.MEM_Write     = memWrite;
   assign bus.MEM_Size      = memSize;
   assign bus.MEM_Address   = memAddr;
   assign bus.MEM_WriteData = memWdata;
   assign bus.Mem_ReadData  = memRdata;

   logic [31:0] ifExpQ[$];
   memExp_t     memExpQ[$];

   int          busy;
   bit          doneNow, owner, lastServed;
   logic [31:0] lastLoad, wdataModel;
   access_t     cur;
   bit          expectZero, running;
   bit          ifActive, memActive, ifGranted, memGranted, ifDone, memDone;
   bit          saturate, issueEnable, dropEnable, resetEnable;
   int          checks, errors;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
      end
   endtask

   // Runs on the falling edge: compare this cycle, then advance the model to the next one.
   task automatic monitorCycle();
      bit      ifElig, memElig, winMem;
      memExp_t e;
      if (expectZero) begin
         checkOutput("reset_if_ready", bus.IF_Ready, 0);
         checkOutput("reset_mem_ready", bus.MEM_Ready, 0);
         checkOutput("reset_if_data", bus.IF_Data, 0);
         checkOutput("reset_mem_read_data", bus.MEM_ReadData, 0);
         checkOutput("reset_mem_size", bus.Mem_Size, 0);
         checkOutput("reset_mem_address", bus.Mem_Address, 0);
         checkOutput("reset_mem_write_data", bus.Mem_WriteData, 0);
         expectZero = 0;
      end
      checkOutput("mem_en", bus.Mem_En, (busy > 0) ? 1 : 0);
      checkOutput("if_ready", bus.IF_Ready, (doneNow && owner == 0) ? 1 : 0);
      checkOutput("mem_ready", bus.MEM_Ready, (doneNow && owner == 1) ? 1 : 0);
      if (busy > 0) begin
         checkOutput("mem_we", bus.Mem_WE, cur.we);
         checkOutput("mem_size", bus.Mem_Size, cur.size);
         checkOutput("mem_address", bus.Mem_Address, cur.addr);
         checkOutput("mem_write_data", bus.Mem_WriteData, wdataModel);
      end else begin
         checkOutput("mem_we_idle", bus.Mem_WE, 0);
      end

      if (bus.IF_Ready === 1'b1) begin
         if (ifExpQ.size() == 0) checkOutput("if_ready_unexpected", 1, 0);
         else checkOutput("if_data", bus.IF_Data, ifExpQ.pop_front());
         ifDone = 1;
      end
      if (bus.MEM_Ready === 1'b1) begin
         if (memExpQ.size() == 0) begin
            checkOutput("mem_ready_unexpected", 1, 0);
         end else begin
            e = memExpQ.pop_front();
            if (!e.isStore) lastLoad = memWord(e.addr);
            checkOutput("mem_read_data", bus.MEM_ReadData, lastLoad);
         end
         memDone = 1;
      end

      memRdata = (busy == 1) ? memWord(cur.addr) : $urandom;

      if (rst) begin
         busy = 0; doneNow = 0; owner = 0; lastServed = 0;
         lastLoad = 0; wdataModel = 0; expectZero = 1;
         ifGranted = 0; memGranted = 0;
         if (ifActive && !ifReq && !ifDone && ifExpQ.size() > 0) begin
            ifExpQ.delete(0);
            ifActive = 0;
         end
         if (memActive && !memReq && !memDone && memExpQ.size() > 0) begin
            memExpQ.delete(0);
            memActive = 0;
         end
      end else if (busy > 0) begin
         busy--;
         doneNow = (busy == 0);
      end else begin
         ifElig  = ifReq  && !(doneNow && owner == 0);
         memElig = memReq && !(doneNow && owner == 1);
         doneNow = 0;
         if (ifElig || memElig) begin
            winMem     = memElig && (!ifElig || lastServed == 0);
            owner      = winMem;
            lastServed = winMem;
            busy       = LAT;
            if (winMem) begin
               cur = '{1'b1, memWrite, memSize, memAddr};
               if (memWrite) wdataModel = memWdata;
               memGranted = 1;
            end else begin
               cur = '{1'b0, 1'b0, 2'b01, ifAddr};
               ifGranted = 1;
            end
         end
      end
   endtask

   task automatic applyStimulus();
      memExp_t e;
      if (ifDone) begin
         ifDone = 0; ifActive = 0; ifGranted = 0; ifReq = 0;
      end
      if (memDone) begin
         memDone = 0; memActive = 0; memGranted = 0; memReq = 0;
      end
      if (dropEnable && ifActive && ifGranted && ifReq && $urandom_range(0, 7) == 0) ifReq = 0;
      if (dropEnable && memActive && memGranted && memReq && $urandom_range(0, 7) == 0) memReq = 0;
      if (issueEnable && !ifActive && (saturate || $urandom_range(0, 2) == 0)) begin
         ifActive = 1;
         ifReq    = 1;
         ifAddr   = $urandom & 32'hFFFF_FFFC;
         ifExpQ.push_back(memWord(ifAddr));
      end
      if (issueEnable && !memActive && (saturate || $urandom_range(0, 2) == 0)) begin
         memActive = 1;
         memReq    = 1;
         memWrite  = 1'($urandom_range(0, 1));
         memSize   = 2'($urandom_range(1, 3));
         memAddr   = $urandom;
         memWdata  = $urandom;
         e = '{memWrite, memAddr};
         memExpQ.push_back(e);
      end
      rst = resetEnable && ($urandom_range(0, 39) == 0);
   endtask

   always @(negedge clk) begin
      if (running) monitorCycle();
   end

   initial begin
      clk = 0; rst = 1;
      ifReq = 0; ifAddr = 0; memReq = 0; memWrite = 0; memSize = 2'b01;
      memAddr = 0; memWdata = 0; memRdata = 0;
      busy = 0; doneNow = 0; owner = 0; lastServed = 0; lastLoad = 0; wdataModel = 0;
      cur = '{1'b0, 1'b0, 2'b01, 32'd0};
      expectZero = 1; running = 0;
      ifActive = 0; memActive = 0; ifGranted = 0; memGranted = 0; ifDone = 0; memDone = 0;
      saturate = 0; issueEnable = 0; dropEnable = 0; resetEnable = 0;
      checks = 0; errors = 0;

      @(posedge clk); #1;
      running = 1;
      @(posedge clk); #1;
      rst = 0;

      $display("[TB] random traffic with mid-access request drops");
      issueEnable = 1; dropEnable = 1;
      repeat (600) begin applyStimulus(); @(posedge clk); #1; end

      $display("[TB] both requesters saturated");
      saturate = 1; dropEnable = 0;
      repeat (400) begin applyStimulus(); @(posedge clk); #1; end

      $display("[TB] random traffic with random resets");
      saturate = 0; dropEnable = 1; resetEnable = 1;
      repeat (800) begin applyStimulus(); @(posedge clk); #1; end

      $display("[TB] draining");
      issueEnable = 0; dropEnable = 0; resetEnable = 0;
      repeat (60) begin applyStimulus(); @(posedge clk); #1; end

      checkOutput("if_queue_drained", ifExpQ.size(), 0);
      checkOutput("mem_queue_drained", memExpQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
